// File: rtl/disp_pkg.sv
// Shared types and constants for the pour-countdown initiator and its down counter.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } disp_state_e;

    localparam int unsigned DISP_DIV_DEFAULT   = 50_000_000;
    localparam int unsigned DISP_STEPS_DEFAULT = 5;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running DIV-cycle counter; tick is high while the count sits at DIV-1.
module tick_prescaler
    import disp_pkg::*;
#(
    parameter int unsigned DIV = DISP_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned    PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/dispense_tick_ctrl.sv
// Pour-countdown initiator: arms the down counter, paces one step ack per DIV cycles,
// drives the pump and flags any cnt0 readback that disagrees with the local step count.
module dispense_tick_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned DIV   = DISP_DIV_DEFAULT,
    parameter int unsigned STEPS = DISP_STEPS_DEFAULT,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             start_req,
    input  logic             abort,
    input  logic [CNT_W-1:0] cnt0_in,
    output logic             count2,
    output logic             count_ACK2,
    output logic             pump_en,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned      AW       = $clog2(STEPS + 1);
    localparam logic [AW-1:0]    ACK_LAST = AW'(STEPS);
    localparam logic [CNT_W-1:0] EXP_BASE = CNT_W'(STEPS - 1);

    disp_state_e      state_q, state_d;
    logic [AW-1:0]    ack_cnt_q, ack_cnt_d;
    logic             start_prev_q, start_prev_d;
    logic             chk_q, chk_d;
    logic             err_q, err_d;

    logic             run;
    logic             tick;
    logic             step;
    logic             start_edge;
    logic [CNT_W-1:0] exp_cnt;

    assign run        = (state_q == ST_RUN);
    assign step       = run && tick;
    assign start_edge = start_req && !start_prev_q;
    // ack_cnt_q already holds k in the cycle after ack k, so the expected remainder follows directly.
    assign exp_cnt    = EXP_BASE - CNT_W'(ack_cnt_q);

    tick_prescaler #(
        .DIV (DIV)
    ) u_presc (
        .clk   (clk),
        .rst_n (RESET),
        .clr   (!run),
        .en    (run),
        .tick  (tick)
    );

    always_comb begin
        state_d      = state_q;
        ack_cnt_d    = ack_cnt_q;
        start_prev_d = start_req;
        chk_d        = step;
        err_d        = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start_edge && !abort) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                ack_cnt_d = '0;
                state_d   = abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (step) begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                    if (ack_cnt_d == ACK_LAST) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_ARM) begin
            err_d = 1'b0;
        end else if (chk_q && (state_q == ST_RUN || state_q == ST_DONE)
                     && (cnt0_in != exp_cnt)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!RESET) begin
            state_q      <= ST_IDLE;
            ack_cnt_q    <= '0;
            start_prev_q <= 1'b0;
            chk_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ack_cnt_q    <= ack_cnt_d;
            start_prev_q <= start_prev_d;
            chk_q        <= chk_d;
            err_q        <= err_d;
        end
    end

    assign count2     = (state_q == ST_ARM);
    assign count_ACK2 = step;
    assign pump_en    = (state_q == ST_ARM) || (state_q == ST_RUN);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign err        = err_q;

endmodule

// File: tb/tb_dispense_tick_ctrl.sv
// Scoreboard bench for dispense_tick_ctrl with DIV=4, STEPS=5, CNT_W=4 and a down-counter model.
module tb_dispense_tick_ctrl;

    localparam int unsigned DIV   = 4;
    localparam int unsigned STEPS = 5;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             RESET;
    logic             start_req;
    logic             abort;
    logic [CNT_W-1:0] cnt0_in;
    logic             count2;
    logic             count_ACK2;
    logic             pump_en;
    logic             busy;
    logic             done;
    logic             err;

    logic [CNT_W-1:0] model_cnt = '0;
    logic             force7;
    logic [5:0]       obs;
    logic [5:0]       exp_v;
    logic [5:0]       sb[$];
    int               checks = 0;
    int               errors = 0;

    always #5 clk = ~clk;

    dispense_tick_ctrl #(
        .DIV   (DIV),
        .STEPS (STEPS),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .RESET      (RESET),
        .start_req  (start_req),
        .abort      (abort),
        .cnt0_in    (cnt0_in),
        .count2     (count2),
        .count_ACK2 (count_ACK2),
        .pump_en    (pump_en),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Down counter: loads STEPS-1 on arm, decrements once per ack.
    always @(posedge clk) begin
        if (count2) model_cnt <= CNT_W'(STEPS - 1);
        else if (count_ACK2) model_cnt <= model_cnt - 1'b1;
    end
    assign cnt0_in = force7 ? CNT_W'(7) : model_cnt;
    assign obs     = {count2, count_ACK2, pump_en, busy, done, err};

    // Expected {count2, ack, pump_en, busy, done, err} j cycles after the start edge E0.
    function automatic logic [5:0] pour_vec(input int j, input logic e);
        logic c2, ack, pmp, bsy, dn;
        c2  = (j == 0);
        ack = (j >= int'(DIV)) && (j <= int'(STEPS * DIV)) && (j % int'(DIV) == 0);
        pmp = (j <= int'(STEPS * DIV));
        bsy = (j <= int'(STEPS * DIV + 1));
        dn  = (j == int'(STEPS * DIV + 1));
        return {c2, ack, pmp, bsy, dn, e};
    endfunction

    task automatic test_reset();
        RESET = 1'b0; start_req = 1'b0; abort = 1'b0; force7 = 1'b0;
        for (int i = 0; i < 5; i++) sb.push_back(6'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin checks++; errors++; $display("FAIL reset sb_empty cyc%0d", i); end
            else begin
                exp_v = sb.pop_front(); checks++;
                if (obs !== exp_v) begin errors++; $display("FAIL reset cyc%0d got %b want %b", i, obs, exp_v); end
            end
            if (i == 2) RESET = 1'b1;
        end
    endtask

    task automatic test_normal_pour();
        for (int j = 0; j <= 22; j++) sb.push_back(pour_vec(j, 1'b0));
        start_req = 1'b1;
        for (int i = 0; i <= 22; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin checks++; errors++; $display("FAIL normal sb_empty cyc%0d", i); end
            else begin
                exp_v = sb.pop_front(); checks++;
                if (obs !== exp_v) begin errors++; $display("FAIL normal j%0d got %b want %b", i, obs, exp_v); end
            end
        end
    endtask

    task automatic test_held_request();
        for (int i = 0; i < 9; i++) sb.push_back(6'b0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin checks++; errors++; $display("FAIL held sb_empty cyc%0d", i); end
            else begin
                exp_v = sb.pop_front(); checks++;
                if (obs !== exp_v) begin errors++; $display("FAIL held cyc%0d got %b want %b", i, obs, exp_v); end
            end
            if (i == 7) start_req = 1'b0;
        end
    endtask

    task automatic test_abort();
        sb.push_back(6'b0);
        for (int j = 0; j <= 9; j++) sb.push_back(pour_vec(j, 1'b0));
        for (int j = 10; j <= 23; j++) sb.push_back(6'b0);
        start_req = 1'b0;
        for (int i = 0; i <= 24; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin checks++; errors++; $display("FAIL abort sb_empty cyc%0d", i); end
            else begin
                exp_v = sb.pop_front(); checks++;
                if (obs !== exp_v) begin errors++; $display("FAIL abort i%0d got %b want %b", i, obs, exp_v); end
            end
            if (i == 0)  start_req = 1'b1;
            if (i == 10) abort = 1'b1;
            if (i == 11) abort = 1'b0;
        end
        start_req = 1'b0;
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 6; i++) sb.push_back(6'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin checks++; errors++; $display("FAIL simul sb_empty cyc%0d", i); end
            else begin
                exp_v = sb.pop_front(); checks++;
                if (obs !== exp_v) begin errors++; $display("FAIL simul cyc%0d got %b want %b", i, obs, exp_v); end
            end
            if (i == 0) begin start_req = 1'b1; abort = 1'b1; end
            if (i == 1) abort = 1'b0;
        end
        start_req = 1'b0;
    endtask

    task automatic test_mismatch();
        sb.push_back(6'b0);
        for (int j = 0; j <= 22; j++) sb.push_back(pour_vec(j, j >= 6));
        sb.push_back(6'b000001);
        for (int j = 0; j <= 22; j++) sb.push_back(pour_vec(j, 1'b0));
        for (int i = 0; i <= 47; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin checks++; errors++; $display("FAIL mismatch sb_empty cyc%0d", i); end
            else begin
                exp_v = sb.pop_front(); checks++;
                if (obs !== exp_v) begin errors++; $display("FAIL mismatch i%0d got %b want %b", i, obs, exp_v); end
            end
            if (i == 0 || i == 24) start_req = 1'b1;
            if (i == 23) start_req = 1'b0;
            if (i == 6)  force7 = 1'b1;
            if (i == 7)  force7 = 1'b0;
        end
        start_req = 1'b0;
    endtask

    task automatic test_reset_mid_pour();
        sb.push_back(6'b0);
        for (int j = 0; j <= 6; j++) sb.push_back(pour_vec(j, 1'b0));
        sb.push_back(6'b0);
        sb.push_back(6'b0);
        for (int j = 0; j <= 22; j++) sb.push_back(pour_vec(j, 1'b0));
        for (int i = 0; i <= 32; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin checks++; errors++; $display("FAIL rstmid sb_empty cyc%0d", i); end
            else begin
                exp_v = sb.pop_front(); checks++;
                if (obs !== exp_v) begin errors++; $display("FAIL rstmid i%0d got %b want %b", i, obs, exp_v); end
            end
            if (i == 0 || i == 9) start_req = 1'b1;
            if (i == 7) begin RESET = 1'b0; start_req = 1'b0; end
            if (i == 8) RESET = 1'b1;
        end
        start_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal_pour();
        test_held_request();
        test_abort();
        test_simultaneous();
        test_mismatch();
        test_reset_mid_pour();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
